// File: rtl/avg_pool2d.sv
// 2x2 stride-2 average pooling over a square unsigned feature map.
// The whole map arrives on one flat bus (row-major, element 0 in the MSBs).
// Every pooled value is computed in parallel and registered once, so latency is one clock.
module avg_pool2d #(
    parameter int IN_SIZE   = 4,
    parameter int BIT_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [IN_SIZE*IN_SIZE*BIT_WIDTH-1:0]          data_in_flat,
    output logic [(IN_SIZE/2)*(IN_SIZE/2)*BIT_WIDTH-1:0]  data_out_flat
);

    localparam int OUT   = IN_SIZE / 2;
    localparam int N_IN  = IN_SIZE * IN_SIZE;
    localparam int N_OUT = OUT * OUT;
    localparam int SUM_W = BIT_WIDTH + 2;

    logic [N_OUT*BIT_WIDTH-1:0] pool_p0;
    logic [N_OUT*BIT_WIDTH-1:0] pool_p1;

    // Fetch pixel (r,c) from the MSB-first row-major input bus.
    function automatic logic [BIT_WIDTH-1:0] pix(
        input logic [N_IN*BIT_WIDTH-1:0] flat,
        input int                        r,
        input int                        c
    );
        return flat[(N_IN - (r*IN_SIZE + c))*BIT_WIDTH - 1 -: BIT_WIDTH];
    endfunction

    // Average of four pixels: a two-bit-wider sum cannot overflow, and dropping the
    // two LSBs is floor division by four (truncation, no rounding). The quotient
    // is at most the largest pixel, so it always fits back into BIT_WIDTH.
    function automatic logic [BIT_WIDTH-1:0] avg4(
        input logic [BIT_WIDTH-1:0] a,
        input logic [BIT_WIDTH-1:0] b,
        input logic [BIT_WIDTH-1:0] c,
        input logic [BIT_WIDTH-1:0] d
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
        return sum[SUM_W-1:2];
    endfunction

    // Stage p0: all windows pooled combinationally and packed MSB-first.
    always_comb begin
        pool_p0 = '0;
        for (int i = 0; i < OUT; i++) begin
            for (int j = 0; j < OUT; j++) begin
                pool_p0[(N_OUT - (i*OUT + j))*BIT_WIDTH - 1 -: BIT_WIDTH] =
                    avg4(pix(data_in_flat, 2*i,     2*j),
                         pix(data_in_flat, 2*i,     2*j + 1),
                         pix(data_in_flat, 2*i + 1, 2*j),
                         pix(data_in_flat, 2*i + 1, 2*j + 1));
            end
        end
    end

    // Stage p1: output register; an asserted reset wipes the pending result immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_p1 <= '0;
        end else begin
            pool_p1 <= pool_p0;
        end
    end

    assign data_out_flat = pool_p1;

endmodule

// File: tb/tb_avg_pool2d.sv
// Bench for avg_pool2d: default 4x8 instance plus a 2x8 and an 8x16 instance,
// all checked against a window-averaging reference model built from plain arithmetic.
module tb_avg_pool2d;

    logic          clk;
    logic          rst;
    logic [127:0]  din4;
    logic [31:0]   dout4;
    logic [31:0]   din2;
    logic [7:0]    dout2;
    logic [1023:0] din8;
    logic [255:0]  dout8;

    int checks;
    int errors;

    int map4 [0:7][0:7];
    int map2 [0:7][0:7];
    int map8 [0:7][0:7];

    avg_pool2d #(.IN_SIZE(4), .BIT_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .data_in_flat(din4), .data_out_flat(dout4));
    avg_pool2d #(.IN_SIZE(2), .BIT_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .data_in_flat(din2), .data_out_flat(dout2));
    avg_pool2d #(.IN_SIZE(8), .BIT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .data_in_flat(din8), .data_out_flat(dout8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Concatenate the map row by row; the first pixel ends up in the MSBs.
    function automatic logic [1023:0] pack_map(input int sz, input int bw, input int m [0:7][0:7]);
        logic [1023:0] f;
        f = '0;
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++)
                f = (f << bw) | 1024'(m[r][c]);
        return f;
    endfunction

    // Reference: floor of the mean of each 2x2 block, emitted row by row.
    function automatic logic [1023:0] ref_pool(input int sz, input int bw, input int m [0:7][0:7]);
        logic [1023:0] e;
        int s;
        e = '0;
        for (int i = 0; i < sz/2; i++)
            for (int j = 0; j < sz/2; j++) begin
                s = m[2*i][2*j] + m[2*i][2*j+1] + m[2*i+1][2*j] + m[2*i+1][2*j+1];
                e = (e << bw) | 1024'(s / 4);
            end
        return e;
    endfunction

    task automatic apply_maps();
        logic [1023:0] t;
        t = pack_map(4, 8, map4);  din4 = t[127:0];
        t = pack_map(2, 8, map2);  din2 = t[31:0];
        t = pack_map(8, 16, map8); din8 = t;
    endtask

    task automatic random_maps();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                map4[r][c] = (r < 4 && c < 4) ? int'($urandom_range(0, 255)) : 0;
                map2[r][c] = (r < 2 && c < 2) ? int'($urandom_range(0, 255)) : 0;
                map8[r][c] = int'($urandom_range(0, 65535));
            end
    endtask

    task automatic fill_all(input int v4, input int v8);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                map4[r][c] = (r < 4 && c < 4) ? v4 : 0;
                map2[r][c] = (r < 2 && c < 2) ? v4 : 0;
                map8[r][c] = v8;
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        random_maps();
        apply_maps();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (dout4 !== 32'h0) begin errors++; $display("FAIL reset_out4: got %h expected %h", dout4, 32'h0); end
        checks++;
        if (dout2 !== 8'h0) begin errors++; $display("FAIL reset_out2: got %h expected %h", dout2, 8'h0); end
        checks++;
        if (dout8 !== 256'h0) begin errors++; $display("FAIL reset_out8: got %h expected 0", dout8); end
    endtask

    task automatic test_ramp();
        logic [1023:0] e;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                map4[r][c] = 4 * (r*4 + c + 1);
        apply_maps();
        rst = 1'b1;
        tick();
        checks++;
        if (dout4 !== 32'h0E162E36) begin errors++; $display("FAIL ramp: got %h expected %h", dout4, 32'h0E162E36); end
        e = ref_pool(4, 8, map4);
        checks++;
        if (dout4 !== e[31:0]) begin errors++; $display("FAIL ramp_model: got %h expected %h", dout4, e[31:0]); end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dout4 !== 32'h0) begin errors++; $display("FAIL async_reset: got %h expected %h", dout4, 32'h0); end
        tick();
        checks++;
        if (dout4 !== 32'h0) begin errors++; $display("FAIL reset_hold: got %h expected %h", dout4, 32'h0); end
        rst = 1'b1;
        tick();
        checks++;
        if (dout4 !== 32'h0E162E36) begin errors++; $display("FAIL reset_release: got %h expected %h", dout4, 32'h0E162E36); end
    endtask

    task automatic test_truncation();
        // windows sum to 5, 6, 7, 4
        int w [0:3][0:3];
        w[0] = '{1, 1, 1, 2};
        w[1] = '{1, 1, 2, 2};
        w[2] = '{1, 2, 2, 2};
        w[3] = '{1, 1, 1, 1};
        for (int k = 0; k < 4; k++) begin
            map4[2*(k/2)][2*(k%2)]       = w[k][0];
            map4[2*(k/2)][2*(k%2)+1]     = w[k][1];
            map4[2*(k/2)+1][2*(k%2)]     = w[k][2];
            map4[2*(k/2)+1][2*(k%2)+1]   = w[k][3];
        end
        apply_maps();
        tick();
        checks++;
        if (dout4 !== 32'h01010101) begin errors++; $display("FAIL truncation: got %h expected %h", dout4, 32'h01010101); end
    endtask

    task automatic test_saturation();
        fill_all(255, 65535);
        apply_maps();
        tick();
        checks++;
        if (dout4 !== 32'hFFFFFFFF) begin errors++; $display("FAIL max_out4: got %h expected %h", dout4, 32'hFFFFFFFF); end
        checks++;
        if (dout2 !== 8'hFF) begin errors++; $display("FAIL max_out2: got %h expected %h", dout2, 8'hFF); end
        checks++;
        if (dout8 !== {256{1'b1}}) begin errors++; $display("FAIL max_out8: got %h expected all ones", dout8); end
        fill_all(0, 0);
        apply_maps();
        tick();
        checks++;
        if (dout4 !== 32'h0) begin errors++; $display("FAIL zero_out4: got %h expected %h", dout4, 32'h0); end
        checks++;
        if (dout8 !== 256'h0) begin errors++; $display("FAIL zero_out8: got %h expected 0", dout8); end
    endtask

    task automatic test_ordering();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                map4[r][c] = 10 * (1 + 2*(r/2) + (c/2));
        apply_maps();
        tick();
        checks++;
        if (dout4 !== 32'h0A141E28) begin errors++; $display("FAIL ordering: got %h expected %h", dout4, 32'h0A141E28); end
    endtask

    task automatic test_back_to_back();
        logic [1023:0] ea4, ea2, ea8, eb4, eb2, eb8;
        random_maps();
        ea4 = ref_pool(4, 8, map4); ea2 = ref_pool(2, 8, map2); ea8 = ref_pool(8, 16, map8);
        apply_maps();
        tick();
        checks++;
        if (dout4 !== ea4[31:0]) begin errors++; $display("FAIL b2b_A_out4: got %h expected %h", dout4, ea4[31:0]); end
        random_maps();
        eb4 = ref_pool(4, 8, map4); eb2 = ref_pool(2, 8, map2); eb8 = ref_pool(8, 16, map8);
        apply_maps();
        #2;
        checks++;
        if (dout4 !== ea4[31:0]) begin errors++; $display("FAIL b2b_hold_A: got %h expected %h", dout4, ea4[31:0]); end
        tick();
        checks++;
        if (dout4 !== eb4[31:0]) begin errors++; $display("FAIL b2b_B_out4: got %h expected %h", dout4, eb4[31:0]); end
        checks++;
        if (dout2 !== eb2[7:0]) begin errors++; $display("FAIL b2b_B_out2: got %h expected %h", dout2, eb2[7:0]); end
        checks++;
        if (dout8 !== eb8[255:0]) begin errors++; $display("FAIL b2b_B_out8: got %h expected %h", dout8, eb8[255:0]); end
        // input changes between edges must not reach the output
        random_maps();
        apply_maps();
        #3;
        checks++;
        if (dout4 !== eb4[31:0]) begin errors++; $display("FAIL b2b_mid_cycle: got %h expected %h", dout4, eb4[31:0]); end
        if (ea2 === eb2 && ea8 === eb8) ; // both references are used above
    endtask

    task automatic test_random_sweep();
        logic [1023:0] e4, e2, e8;
        for (int n = 0; n < 40; n++) begin
            random_maps();
            e4 = ref_pool(4, 8, map4); e2 = ref_pool(2, 8, map2); e8 = ref_pool(8, 16, map8);
            apply_maps();
            tick();
            checks++;
            if (dout4 !== e4[31:0]) begin errors++; $display("FAIL rand_out4[%0d]: got %h expected %h", n, dout4, e4[31:0]); end
            checks++;
            if (dout2 !== e2[7:0]) begin errors++; $display("FAIL rand_out2[%0d]: got %h expected %h", n, dout2, e2[7:0]); end
            checks++;
            if (dout8 !== e8[255:0]) begin errors++; $display("FAIL rand_out8[%0d]: got %h expected %h", n, dout8, e8[255:0]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b0;
        din4 = '0;
        din2 = '0;
        din8 = '0;
        fill_all(0, 0);
        test_reset();
        test_ramp();
        test_async_reset();
        test_truncation();
        test_saturation();
        test_ordering();
        test_back_to_back();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
